// File: rtl/alu_exec_ctrl_pkg.sv
// Shared definitions for the execute-stage controller: ALU opcodes, FSM
// state encoding, instruction field positions and datapath defaults.
package alu_exec_ctrl_pkg;

    localparam int DATA_W_DEF  = 4;
    localparam int REG_CNT_DEF = 4;

    // Instruction layout, LSB first: nowb, rs, rd, op.
    localparam int OP_W     = 3;
    localparam int NOWB_POS = 0;
    localparam int RS_POS   = 1;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_NOT = 3'b101,
        ALU_INC = 3'b110,
        ALU_DEC = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    // rd sits directly above rs, op directly above rd.
    function automatic int rd_pos(input int aw);
        return RS_POS + aw;
    endfunction

    function automatic int op_pos(input int aw);
        return RS_POS + 2 * aw;
    endfunction

endpackage

// File: rtl/alu_exec_ctrl_exec_regfile.sv
// Register file for the execute stage: two asynchronous operand read ports,
// one asynchronous debug read port, an external load port and a writeback
// port. When both write ports target the same register, writeback wins.
module exec_regfile
    import alu_exec_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_CNT = REG_CNT_DEF,
    localparam int REG_AW = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              ld_en,
    input  logic [REG_AW-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    logic [DATA_W-1:0] regs [REG_CNT];

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];
    assign dbg_data  = regs[dbg_addr];

    // Storage update; the writeback assignment comes last so it overrides a
    // same-register load in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (ld_en) begin
                regs[ld_addr] <= ld_data;
            end
            if (wb_en) begin
                regs[wb_addr] <= wb_data;
            end
        end
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller sitting upstream of the ALU. Each instruction walks
// IDLE -> EXEC -> WB: operands are registered onto the ALU inputs at accept,
// the ALU outputs are captured at the end of EXEC, and the result and flags
// retire in WB.
// Optional build macro: RETIRE_CNT_EN adds a 16-bit retired-instruction counter.
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high. instr_ready depends only on state and rst, never
// on instr_valid; the source holds instr stable while instr_valid is high and
// not yet accepted.
module alu_exec_ctrl
    import alu_exec_ctrl_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int REG_CNT  = REG_CNT_DEF,
    localparam int REG_AW  = $clog2(REG_CNT),
    localparam int INSTR_W = OP_W + 2 * REG_AW + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [OP_W-1:0]    alu_op,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_carry,
    input  logic               alu_zero,
    input  logic               ld_en,
    input  logic [REG_AW-1:0]  ld_addr,
    input  logic [DATA_W-1:0]  ld_data,
    output logic               flag_c,
    output logic               flag_z,
    output logic               wb_valid,
    output logic [REG_AW-1:0]  wb_addr,
    output logic [DATA_W-1:0]  wb_data,
`ifdef RETIRE_CNT_EN
    output logic [15:0]        retire_cnt,
`endif
    input  logic [REG_AW-1:0]  dbg_sel,
    output logic [DATA_W-1:0]  dbg_data
);

    localparam int RD_POS = rd_pos(REG_AW);
    localparam int OP_POS = op_pos(REG_AW);

    state_e state;
    state_e state_nxt;

    logic              accept;
    logic [OP_W-1:0]   instr_op;
    logic [REG_AW-1:0] instr_rd;
    logic [REG_AW-1:0] instr_rs;
    logic              instr_nowb;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;

    logic [REG_AW-1:0] rd_q;
    logic              nowb_q;
    logic [DATA_W-1:0] res_q;
    logic              carry_q;
    logic              zero_q;
    logic              wb_we;

    assign instr_op   = instr[OP_POS +: OP_W];
    assign instr_rd   = instr[RD_POS +: REG_AW];
    assign instr_rs   = instr[RS_POS +: REG_AW];
    assign instr_nowb = instr[NOWB_POS];

    // Gating with rst keeps a reset cycle from accepting or retiring anything.
    assign instr_ready = (state == ST_IDLE) & ~rst;
    assign accept      = instr_valid & instr_ready;
    assign wb_valid    = (state == ST_WB) & ~rst;
    assign wb_we       = wb_valid & ~nowb_q;
    assign wb_addr     = rd_q;
    assign wb_data     = res_q;

    exec_regfile #(
        .DATA_W  (DATA_W),
        .REG_CNT (REG_CNT)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (instr_rd),
        .rd_data_a (rd_val),
        .rd_addr_b (instr_rs),
        .rd_data_b (rs_val),
        .dbg_addr  (dbg_sel),
        .dbg_data  (dbg_data),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .wb_en     (wb_we),
        .wb_addr   (rd_q),
        .wb_data   (res_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one cycle each in EXEC and WB.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_WB;
            ST_WB:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: latch operands at accept, capture ALU outputs at end of EXEC,
    // commit flags at end of WB. ALU inputs hold their values otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            nowb_q  <= 1'b0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            flag_c  <= 1'b0;
            flag_z  <= 1'b0;
        end else begin
            if (accept) begin
                rd_q   <= instr_rd;
                nowb_q <= instr_nowb;
                alu_a  <= rd_val;
                alu_b  <= rs_val;
                alu_op <= instr_op;
            end
            if (state == ST_EXEC) begin
                res_q   <= alu_result;
                carry_q <= alu_carry;
                zero_q  <= alu_zero;
            end
            if (state == ST_WB) begin
                flag_c <= carry_q;
                flag_z <= zero_q;
            end
        end
    end

`ifdef RETIRE_CNT_EN
    // Retired-instruction counter; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (wb_valid) begin
            retire_cnt <= retire_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed testbench for alu_exec_ctrl with a behavioural 4-bit ALU attached.
// Build with RETIRE_CNT_EN defined to also check the retire counter.
module tb_alu_exec_ctrl;

    logic       clk;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_result;
    logic       alu_carry;
    logic       alu_zero;
    logic       ld_en;
    logic [1:0] ld_addr;
    logic [3:0] ld_data;
    logic       flag_c;
    logic       flag_z;
    logic       wb_valid;
    logic [1:0] wb_addr;
    logic [3:0] wb_data;
    logic [1:0] dbg_sel;
    logic [3:0] dbg_data;
`ifdef RETIRE_CNT_EN
    logic [15:0] retire_cnt;
    int          retire_base;
`endif

    int compared;
    int mismatched;
    int wb_pulses;

    // Observations captured by exec_instr
    int         obs_lat;
    logic [3:0] obs_a;
    logic [3:0] obs_b;
    logic [2:0] obs_op;
    logic       obs_ready_exec;
    logic       obs_ready_wb;
    logic [1:0] obs_wb_addr;
    logic [3:0] obs_wb_data;

    alu_exec_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_carry   (alu_carry),
        .alu_zero    (alu_zero),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .flag_c      (flag_c),
        .flag_z      (flag_z),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
`ifdef RETIRE_CNT_EN
        .retire_cnt  (retire_cnt),
`endif
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU
    always_comb begin
        alu_result = 4'h0;
        alu_carry  = 1'b0;
        case (alu_op)
            3'd0: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1: begin
                alu_result = alu_a - alu_b;
                alu_carry  = (alu_a < alu_b);
            end
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_a | alu_b;
            3'd4: alu_result = alu_a ^ alu_b;
            3'd5: alu_result = ~alu_a;
            3'd6: alu_result = alu_a + 4'd1;
            default: alu_result = alu_a - 4'd1;
        endcase
    end
    assign alu_zero = (alu_result == 4'h0);

    // Count retire pulses (pre-edge value at each rising edge)
    always @(posedge clk) begin
        if (wb_valid === 1'b1) wb_pulses++;
    end

    // ---------------- driver tasks ----------------
    task automatic load_reg(input logic [1:0] a, input logic [3:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [3:0] d);
        dbg_sel = a;
        #1;
        d = dbg_data;
    endtask

    // Issue one instruction and follow it to retirement (bounded waits).
    task automatic exec_instr(input logic [7:0] ins);
        int n;
        @(negedge clk);
        instr = ins; instr_valid = 1'b1;
        n = 0;
        while (instr_ready !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        instr_valid = 1'b0;
        obs_a = alu_a; obs_b = alu_b; obs_op = alu_op;
        obs_ready_exec = instr_ready;
        obs_lat = -1; obs_ready_wb = 1'bx; obs_wb_addr = 'x; obs_wb_data = 'x;
        n = 1;
        while (n < 8) begin
            if (wb_valid === 1'b1) begin
                obs_lat = n; obs_wb_addr = wb_addr; obs_wb_data = wb_data;
                obs_ready_wb = instr_ready;
                break;
            end
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [3:0] d;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared++;
        if (instr_ready !== 1'b0) begin
            mismatched++; $display("FAIL reset_ready_in_rst: got %b expected 0", instr_ready);
        end
        rst = 1'b0;
        #1;
        compared++;
        if (instr_ready !== 1'b1) begin
            mismatched++; $display("FAIL reset_ready: got %b expected 1", instr_ready);
        end
        compared++;
        if ({wb_valid, flag_c, flag_z} !== 3'b000) begin
            mismatched++; $display("FAIL reset_flags: got %b expected 000", {wb_valid, flag_c, flag_z});
        end
        compared++;
        if ({alu_a, alu_b, alu_op, wb_addr, wb_data} !== 17'h0) begin
            mismatched++; $display("FAIL reset_outs: got %h expected 0", {alu_a, alu_b, alu_op, wb_addr, wb_data});
        end
        for (int r = 0; r < 4; r++) begin
            read_reg(r[1:0], d);
            compared++;
            if (d !== 4'h0) begin
                mismatched++; $display("FAIL reset_reg%0d: got %h expected 0", r, d);
            end
        end
    endtask

    task automatic test_add();
        logic [3:0] d;
        load_reg(2'd0, 4'h5);
        load_reg(2'd1, 4'h3);
        exec_instr(8'h02);
        compared++;
        if (obs_lat !== 2) begin
            mismatched++; $display("FAIL add_latency: got %0d expected 2", obs_lat);
        end
        compared++;
        if ({obs_a, obs_b, obs_op} !== {4'h5, 4'h3, 3'd0}) begin
            mismatched++; $display("FAIL add_alu_in: got %h/%h/%h expected 5/3/0", obs_a, obs_b, obs_op);
        end
        compared++;
        if ({obs_ready_exec, obs_ready_wb} !== 2'b00) begin
            mismatched++; $display("FAIL add_ready_busy: got %b expected 00", {obs_ready_exec, obs_ready_wb});
        end
        compared++;
        if ({obs_wb_addr, obs_wb_data} !== {2'd0, 4'h8}) begin
            mismatched++; $display("FAIL add_wb: got %h/%h expected 0/8", obs_wb_addr, obs_wb_data);
        end
        read_reg(2'd0, d);
        compared++;
        if (d !== 4'h8) begin
            mismatched++; $display("FAIL add_r0: got %h expected 8", d);
        end
        compared++;
        if ({flag_c, flag_z, wb_valid, instr_ready} !== 4'b0001) begin
            mismatched++; $display("FAIL add_after: got %b expected 0001", {flag_c, flag_z, wb_valid, instr_ready});
        end
    endtask

    task automatic test_sub_xor();
        logic [3:0] d;
        load_reg(2'd0, 4'h2);
        load_reg(2'd1, 4'h3);
        exec_instr(8'h22);
        read_reg(2'd0, d);
        compared++;
        if ({d, flag_c, flag_z} !== {4'hF, 1'b1, 1'b0}) begin
            mismatched++; $display("FAIL sub: got r0=%h c=%b z=%b expected r0=f c=1 z=0", d, flag_c, flag_z);
        end
        exec_instr(8'h80);
        compared++;
        if ({obs_a, obs_b} !== 8'hFF) begin
            mismatched++; $display("FAIL xor_same_reg: got %h/%h expected f/f", obs_a, obs_b);
        end
        read_reg(2'd0, d);
        compared++;
        if ({d, flag_c, flag_z} !== {4'h0, 1'b0, 1'b1}) begin
            mismatched++; $display("FAIL xor: got r0=%h c=%b z=%b expected r0=0 c=0 z=1", d, flag_c, flag_z);
        end
    endtask

    task automatic test_nowb();
        logic [3:0] d;
        load_reg(2'd3, 4'h1);
        load_reg(2'd2, 4'hF);
        exec_instr(8'h1E);           // ADD r3,r3 -> 2, clears Z
        compared++;
        if ({flag_z, obs_wb_data} !== {1'b0, 4'h2}) begin
            mismatched++; $display("FAIL nowb_pre: got z=%b wb=%h expected z=0 wb=2", flag_z, obs_wb_data);
        end
        exec_instr(8'hD5);           // INC r2, nowb
        compared++;
        if ({obs_lat, obs_wb_addr, obs_wb_data} !== {32'sd2, 2'd2, 4'h0}) begin
            mismatched++; $display("FAIL nowb_wb: got lat=%0d addr=%h data=%h expected 2/2/0", obs_lat, obs_wb_addr, obs_wb_data);
        end
        read_reg(2'd2, d);
        compared++;
        if ({d, flag_c, flag_z} !== {4'hF, 1'b0, 1'b1}) begin
            mismatched++; $display("FAIL nowb_state: got r2=%h c=%b z=%b expected r2=f c=0 z=1", d, flag_c, flag_z);
        end
    endtask

    task automatic test_logic_ops();
        logic [7:0] ins [4];
        logic [3:0] exp_d [4];
        logic [1:0] exp_a [4];
        logic [3:0] d;
        ins   = '{8'h57, 8'h77, 8'hB7, 8'hF8};   // AND, OR, NOT (nowb) r2,r3; DEC r3
        exp_d = '{4'h8, 4'hE, 4'h3, 4'h9};
        exp_a = '{2'd2, 2'd2, 2'd2, 2'd3};
        load_reg(2'd2, 4'hC);
        load_reg(2'd3, 4'hA);
        for (int i = 0; i < 4; i++) begin
            exec_instr(ins[i]);
            compared++;
            if ({obs_wb_addr, obs_wb_data, flag_c} !== {exp_a[i], exp_d[i], 1'b0}) begin
                mismatched++;
                $display("FAIL logic_op%0d: got addr=%h data=%h c=%b expected addr=%h data=%h c=0",
                         i, obs_wb_addr, obs_wb_data, flag_c, exp_a[i], exp_d[i]);
            end
        end
        read_reg(2'd2, d);
        compared++;
        if (d !== 4'hC) begin
            mismatched++; $display("FAIL logic_r2: got %h expected c", d);
        end
        read_reg(2'd3, d);
        compared++;
        if (d !== 4'h9) begin
            mismatched++; $display("FAIL logic_r3: got %h expected 9", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] d;
        int acc [3];
        int idx;
        int p0;
        load_reg(2'd0, 4'h1);
        load_reg(2'd1, 4'h1);
        acc = '{-1, -1, -1};
        idx = 0;
        p0 = wb_pulses;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (idx < 3) begin
                instr = 8'h02; instr_valid = 1'b1;
            end else begin
                instr_valid = 1'b0;
            end
            #1;
            if (instr_valid && instr_ready) begin
                acc[idx] = k;
                idx++;
            end
        end
        instr_valid = 1'b0;
        @(negedge clk);
        compared++;
        if (acc[0] != 0 || acc[1] != 3 || acc[2] != 6) begin
            mismatched++; $display("FAIL b2b_accepts: got %0d,%0d,%0d expected 0,3,6", acc[0], acc[1], acc[2]);
        end
        compared++;
        if (wb_pulses - p0 != 3) begin
            mismatched++; $display("FAIL b2b_pulses: got %0d expected 3", wb_pulses - p0);
        end
        read_reg(2'd0, d);
        compared++;
        if (d !== 4'h4) begin
            mismatched++; $display("FAIL b2b_r0: got %h expected 4", d);
        end
    endtask

    task automatic test_reset_abort();
        logic [3:0] d;
        int p0;
        load_reg(2'd0, 4'h5);
        load_reg(2'd1, 4'h3);
        p0 = wb_pulses;
        @(negedge clk);
        instr = 8'h02; instr_valid = 1'b1;
        @(negedge clk);                  // EXEC
        instr_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        compared++;
        if (instr_ready !== 1'b0) begin
            mismatched++; $display("FAIL abort_ready_in_rst: got %b expected 0", instr_ready);
        end
        rst = 1'b0;
        #1;
        compared++;
        if (instr_ready !== 1'b1) begin
            mismatched++; $display("FAIL abort_ready: got %b expected 1", instr_ready);
        end
        repeat (3) @(negedge clk);
        compared++;
        if (wb_pulses != p0) begin
            mismatched++; $display("FAIL abort_no_wb: got %0d pulses expected 0", wb_pulses - p0);
        end
        compared++;
        if ({alu_a, alu_b, alu_op, wb_addr, wb_data, flag_c, flag_z} !== 19'h0) begin
            mismatched++; $display("FAIL abort_outs: got %h expected 0", {alu_a, alu_b, alu_op, wb_addr, wb_data, flag_c, flag_z});
        end
        for (int r = 0; r < 4; r++) begin
            read_reg(r[1:0], d);
            compared++;
            if (d !== 4'h0) begin
                mismatched++; $display("FAIL abort_reg%0d: got %h expected 0", r, d);
            end
        end
`ifdef RETIRE_CNT_EN
        compared++;
        if (retire_cnt !== 16'd0) begin
            mismatched++; $display("FAIL abort_retire_cnt: got %0d expected 0", retire_cnt);
        end
        retire_base = wb_pulses;
`endif
    endtask

    task automatic test_ld_collision();
        logic [3:0] d;
        load_reg(2'd0, 4'h6);
        load_reg(2'd1, 4'h7);
        @(negedge clk);
        instr = 8'h08; instr_valid = 1'b1;      // ADD r1,r0
        @(negedge clk);                          // EXEC
        instr_valid = 1'b0;
        @(negedge clk);                          // WB, collide with load
        ld_en = 1'b1; ld_addr = 2'd1; ld_data = 4'h5;
        compared++;
        if ({wb_valid, wb_addr, wb_data} !== {1'b1, 2'd1, 4'hD}) begin
            mismatched++; $display("FAIL coll_wb: got %b/%h/%h expected 1/1/d", wb_valid, wb_addr, wb_data);
        end
        @(negedge clk);
        ld_en = 1'b0;
        read_reg(2'd1, d);
        compared++;
        if (d !== 4'hD) begin
            mismatched++; $display("FAIL coll_r1: got %h expected d", d);
        end
        // Load in accept cycle must not affect the operand read.
        @(negedge clk);
        instr = 8'h02; instr_valid = 1'b1;      // ADD r0,r1
        ld_en = 1'b1; ld_addr = 2'd1; ld_data = 4'h1;
        @(negedge clk);
        instr_valid = 1'b0; ld_en = 1'b0;
        compared++;
        if ({alu_a, alu_b} !== 8'h6D) begin
            mismatched++; $display("FAIL accept_ld_operands: got %h/%h expected 6/d", alu_a, alu_b);
        end
        repeat (2) @(negedge clk);
        read_reg(2'd0, d);
        compared++;
        if ({d, flag_c, flag_z} !== {4'h3, 1'b1, 1'b0}) begin
            mismatched++; $display("FAIL accept_ld_result: got r0=%h c=%b z=%b expected r0=3 c=1 z=0", d, flag_c, flag_z);
        end
        read_reg(2'd1, d);
        compared++;
        if (d !== 4'h1) begin
            mismatched++; $display("FAIL accept_ld_r1: got %h expected 1", d);
        end
`ifdef RETIRE_CNT_EN
        compared++;
        if (retire_cnt !== 16'(wb_pulses - retire_base)) begin
            mismatched++; $display("FAIL retire_cnt: got %0d expected %0d", retire_cnt, wb_pulses - retire_base);
        end
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        compared = 0; mismatched = 0; wb_pulses = 0;
        rst = 1'b1; instr_valid = 1'b0; instr = 8'h00;
        ld_en = 1'b0; ld_addr = 2'd0; ld_data = 4'h0; dbg_sel = 2'd0;
`ifdef RETIRE_CNT_EN
        retire_base = 0;
`endif
        test_reset();
        test_add();
        test_sub_xor();
        test_nowb();
        test_logic_ops();
        test_back_to_back();
        test_reset_abort();
        test_ld_collision();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Execute-stage controller for the 4-bit processor; sits directly upstream of the ALU.
- Accepts one decoded instruction per transaction via valid/ready and reads two operands from an internal register file.
- Drives the ALU operand and opcode inputs, captures the ALU result/carry/zero, then writes the result back and updates the C/Z flags.
- External load port preloads registers; debug read port exposes register contents.

Parameters:
- DATA_W, 4, datapath width; must match the ALU width.
- REG_CNT, 4, number of general registers; power of 2; REG_AW = log2(REG_CNT).
- INSTR_W, 3+2*REG_AW+1 (8 at defaults), instruction width; derived, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller can accept
- instr  in  INSTR_W  [7:5] op, [4:3] rd, [2:1] rs, [0] nowb (1 = flags only, no register write)
- alu_a  out  DATA_W  ALU operand A = reg[rd]
- alu_b  out  DATA_W  ALU operand B = reg[rs]
- alu_op  out  3  ALU opcode
- alu_result  in  DATA_W  ALU result
- alu_carry  in  1  ALU carry/borrow
- alu_zero  in  1  ALU zero flag
- ld_en  in  1  external register load strobe
- ld_addr  in  REG_AW  load target
- ld_data  in  DATA_W  load value
- flag_c  out  1  registered carry flag
- flag_z  out  1  registered zero flag
- wb_valid  out  1  one-cycle pulse on retire
- wb_addr  out  REG_AW  retired destination
- wb_data  out  DATA_W  retired result
- dbg_sel  in  REG_AW  debug register select
- dbg_data  out  DATA_W  combinational reg[dbg_sel]

Behaviour:
- Reset: state=IDLE; all registers, flag_c, flag_z, alu_a, alu_b, alu_op, wb_valid, wb_addr, wb_data = 0.
- instr_ready = (state==IDLE) & ~rst.
- FSM IDLE -> EXEC -> WB -> IDLE, one cycle per state outside IDLE.
- IDLE: on instr_valid & instr_ready, latch op/rd/nowb; register alu_a=reg[rd], alu_b=reg[rs], alu_op=op; go to EXEC.
- EXEC: ALU inputs are stable for the whole cycle. At the end of the cycle, capture alu_result, alu_carry and alu_zero into holding registers; go to WB.
- WB: write the held result to reg[rd] unless nowb=1. Update flag_c/flag_z from the held values, including when nowb=1. Assert wb_valid for this cycle only, with wb_addr=rd and wb_data=result (driven also when nowb=1). Go to IDLE.
- Throughput: one instruction per 3 cycles. Accept-to-wb_valid latency is 2 cycles.
- alu_a/alu_b/alu_op hold their last values outside EXEC.
- Flags change only in WB; the ALU sets carry=0 for non-ADD/SUB ops, so flag_c clears on those ops.
- ld_en:
  - Honoured in any state and written at the clock edge.
  - If ld_en targets the same register as a same-cycle WB write, WB wins.
  - A load in the accept cycle is not seen by that instruction's operand read, which uses pre-edge values.
- rd==rs is legal; both operands get the same value.
- A reset asserted in any state aborts the operation: no writeback, no wb_valid, full reset values.
- instr_valid while not ready is ignored; the upstream source holds it until accepted.

Optional Feature:
- Macro RETIRE_CNT_EN.
- When defined: adds output retire_cnt (16 bits). It resets to 0, increments on every wb_valid, and wraps 0xFFFF -> 0.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package: ALU opcode constants (ADD=000, SUB=001, AND=010, OR=011, XOR=100, NOT=101, INC=110, DEC=111), FSM state encoding, instruction field offsets, DATA_W default.
- One natural sub-module: exec_regfile (REG_CNT x DATA_W, two async read ports, one debug read port, two write ports with WB priority).

Test Plan:
- Reset, then load r0=5 and r1=3; issue ADD r0,r1 (instr 0x02) -> wb_valid 2 cycles after accept, r0=8, flag_c=0, flag_z=0, instr_ready low for 2 cycles.
- r0=2, r1=3; issue SUB r0,r1 -> r0=0xF, flag_c=1, flag_z=0. Then XOR r0,r0 (0x80) -> r0=0, flag_z=1, flag_c=0.
- r2=0xF; issue INC r2 with nowb=1 -> r2 stays 0xF, wb_data=0, flag_z=1.
- Back-to-back instr_valid held high for 3 instructions -> accepted on cycles 0, 3, 6 only; three wb_valid pulses.
- Assert rst during EXEC of ADD -> no wb_valid, all registers 0, instr_ready=1 on the first cycle after rst deasserts.
- ld_en to r1 in the same cycle as a WB to r1 -> r1 holds the ALU result. With RETIRE_CNT_EN defined, retire_cnt counts wb_valid pulses.
